spi_cmd_bridge: RTL and testbench

Parametrised command decoder between the SPI slave byte engine and the SDIO capture FIFOs. Decodes opcode/argument byte streams from the SPI master into register writes, register reads, FIFO level reads and length-prefixed burst reads from one of `NUM_CH` byte FIFOs. Read responses are placed on the SPI transmit byte for the next frame. Successor to the single-channel control/FIFO command logic, adding addressed registers, multiple channels, underrun handling and frame abort.

---
 rtl/spi_bridge_pkg.sv | 25 ++
 rtl/spi_burst_reader.sv | 146 ++++++++++++++
 rtl/spi_cmd_bridge.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg
// Shared definitions for the SPI command bridge: command opcodes, the
// sequencing state encoding used by the decoder and the burst reader, and
// the default byte returned when a burst finds its FIFO empty.
package spi_bridge_pkg;

    localparam logic [7:0] OP_WR_REG    = 8'h02;
    localparam logic [7:0] OP_RD_REG    = 8'h03;
    localparam logic [7:0] OP_RD_LVL    = 8'h05;
    localparam logic [7:0] OP_RD_UNDR   = 8'h07;
    localparam logic [7:0] OP_BURST     = 8'hCC;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ARG1,
        ARG2,
        BURST_RD,
        BURST_LD,
        BURST_WAIT,
        BURST_CSUM
    } state_t;

endpackage

// File: rtl/spi_burst_reader.sv
// spi_burst_reader
// Burst sequencer: fetches len bytes from one FIFO channel, one byte per SPI
// frame, substituting FILL (and flagging underrun) when the channel is empty.
// Optional macro SPI_CMD_BRIDGE_CSUM_EN appends one frame with the XOR of all
// bytes sent.
//
// state      | meaning
// IDLE       | no burst active, waiting for i_start
// BURST_RD   | strobe the FIFO (or note empty and flag underrun)
// BURST_LD   | hand fetched byte or FILL to the tx register, count it
// BURST_WAIT | wait for the frame to finish shifting out
// BURST_CSUM | checksum frame loaded, wait for it to finish
//
// Ports:
//   clk, rst          clock, async active-low reset
//   i_start           start pulse, i_ch / i_len valid with it
//   i_ch, i_len       channel index (already range-checked), byte count (>0)
//   i_abort           frame inactive (ssel_n); forces IDLE
//   i_tx_done         current tx byte fully shifted
//   i_fifo_empty      per-channel empty flags
//   i_fifo_rd_data    per-channel FIFO outputs, valid 1 cycle after strobe
//   o_fifo_rd_en      one-hot read strobes
//   o_underrun_set    per-channel underrun set pulses
//   o_tx_ld, o_tx_byte load request and byte for the tx register
//   o_busy            burst in progress
module spi_burst_reader
    import spi_bridge_pkg::*;
#(
    parameter int         NUM_CH = 2,
    parameter logic [7:0] FILL   = FILL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [7:0]            i_ch,
    input  logic [7:0]            i_len,
    input  logic                  i_abort,
    input  logic                  i_tx_done,
    input  logic [NUM_CH-1:0]     i_fifo_empty,
    input  logic [8*NUM_CH-1:0]   i_fifo_rd_data,
    output logic [NUM_CH-1:0]     o_fifo_rd_en,
    output logic [NUM_CH-1:0]     o_underrun_set,
    output logic                  o_tx_ld,
    output logic [7:0]            o_tx_byte,
    output logic                  o_busy
);
    state_t            r_state, w_state_nxt;
    logic [7:0]        r_ch;
    logic [8:0]        r_len, r_cnt;
    logic              r_fill;
    logic [NUM_CH-1:0] w_ch_oh;
    logic              w_empty;
    logic [7:0]        w_data;
`ifdef SPI_CMD_BRIDGE_CSUM_EN
    logic [7:0]        r_csum;
`endif

    always_comb begin
        w_ch_oh = '0;
        w_empty = 1'b1;
        w_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == 8'(k)) begin
                w_ch_oh[k] = 1'b1;
                w_empty    = i_fifo_empty[k];
                w_data     = i_fifo_rd_data[8*k +: 8];
            end
        end
    end

    assign o_busy = (r_state != IDLE);

    // Strobes are combinational so an abort drops fifo_rd_en in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        o_fifo_rd_en   = '0;
        o_underrun_set = '0;
        o_tx_ld        = 1'b0;
        o_tx_byte      = r_fill ? FILL : w_data;
        if (r_state != IDLE && i_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_start) w_state_nxt = BURST_RD;
                BURST_RD: begin
                    if (w_empty) o_underrun_set = w_ch_oh;
                    else         o_fifo_rd_en   = w_ch_oh;
                    w_state_nxt = BURST_LD;
                end
                BURST_LD: begin
                    o_tx_ld     = 1'b1;
                    w_state_nxt = BURST_WAIT;
                end
                BURST_WAIT: begin
                    if (i_tx_done) begin
                        if (r_cnt == r_len) begin
`ifdef SPI_CMD_BRIDGE_CSUM_EN
                            // Checksum goes out on the frame right after the last data byte.
                            o_tx_ld     = 1'b1;
                            o_tx_byte   = r_csum;
                            w_state_nxt = BURST_CSUM;
`else
                            w_state_nxt = IDLE;
`endif
                        end else begin
                            w_state_nxt = BURST_RD;
                        end
                    end
                end
                BURST_CSUM: if (i_tx_done) w_state_nxt = IDLE;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fill  <= 1'b0;
`ifdef SPI_CMD_BRIDGE_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && i_start) begin
                r_ch   <= i_ch;
                r_len  <= {1'b0, i_len};
                r_cnt  <= '0;
`ifdef SPI_CMD_BRIDGE_CSUM_EN
                r_csum <= '0;
`endif
            end
            if (r_state == BURST_RD && !i_abort) r_fill <= w_empty;
            if (r_state == BURST_LD && !i_abort) begin
                r_cnt  <= r_cnt + 9'd1;
`ifdef SPI_CMD_BRIDGE_CSUM_EN
                r_csum <= r_csum ^ o_tx_byte;
`endif
            end
        end
    end

endmodule

// File: rtl/spi_cmd_bridge.sv
// spi_cmd_bridge
// Decodes SPI opcode/argument byte streams into control register writes,
// register/level/underrun reads and FIFO burst reads. Read responses land on
// spi_tx_data for the next SPI frame. Optional macro SPI_CMD_BRIDGE_CSUM_EN
// (see spi_burst_reader) adds a checksum frame after each burst.
//
// state | meaning
// IDLE  | waiting for an opcode (also held while a burst runs)
// ARG1  | opcode accepted, waiting for addr/ch
// ARG2  | waiting for write data or burst length
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   ssel_n                   SPI chip select (synchronised), high = no frame
//   spi_rx_data/valid        received byte and its one-cycle strobe
//   spi_tx_done              current tx byte fully shifted
//   spi_tx_data              byte for the next frame
//   ctrl_regs                control registers, reg k at [8k+7:8k]
//   fifo_rd_en/rd_data       one-hot FIFO strobes / outputs (1-cycle latency)
//   fifo_empty, fifo_level   per-channel status
//   underrun                 sticky per-channel underrun flags
module spi_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter int         NUM_CH   = 2,
    parameter int         NUM_REGS = 4,
    parameter int         LVL_W    = 6,
    parameter logic [7:0] FILL     = FILL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ssel_n,
    input  logic [7:0]              spi_rx_data,
    input  logic                    spi_rx_valid,
    input  logic                    spi_tx_done,
    output logic [7:0]              spi_tx_data,
    output logic [8*NUM_REGS-1:0]   ctrl_regs,
    output logic [NUM_CH-1:0]       fifo_rd_en,
    input  logic [8*NUM_CH-1:0]     fifo_rd_data,
    input  logic [NUM_CH-1:0]       fifo_empty,
    input  logic [LVL_W*NUM_CH-1:0] fifo_level,
    output logic [NUM_CH-1:0]       underrun
);
    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);
    localparam int         LVL_CPY  = (LVL_W < 8) ? LVL_W : 8;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_op, r_arg1, r_tx;
    logic [8*NUM_REGS-1:0] r_ctrl;
    logic [NUM_CH-1:0]     r_underrun, w_undr_set;
    logic                  w_rx, w_busy, w_reg_we, w_tx_ld, w_undr_clr, w_start, w_burst_ld;
    logic [7:0]            w_tx_byte, w_reg_rd, w_lvl_rd, w_undr_byte, w_burst_byte;

    // Bytes arriving during a burst are master dummies.
    assign w_rx = spi_rx_valid && !w_busy;

    always_comb begin
        w_reg_rd    = '0;
        w_lvl_rd    = '0;
        w_undr_byte = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (spi_rx_data == 8'(k)) w_reg_rd = r_ctrl[8*k +: 8];
        for (int k = 0; k < NUM_CH; k++)
            if (spi_rx_data == 8'(k)) w_lvl_rd[LVL_CPY-1:0] = fifo_level[LVL_W*k +: LVL_CPY];
        w_undr_byte[NUM_CH-1:0] = r_underrun;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reg_we    = 1'b0;
        w_tx_ld     = 1'b0;
        w_tx_byte   = r_tx;
        w_undr_clr  = 1'b0;
        w_start     = 1'b0;
        if (r_state != IDLE && ssel_n) begin
            w_state_nxt = IDLE;
        end else if (w_rx) begin
            case (r_state)
                IDLE: begin
                    case (spi_rx_data)
                        OP_WR_REG, OP_RD_REG, OP_RD_LVL, OP_BURST: w_state_nxt = ARG1;
                        OP_RD_UNDR: begin
                            w_tx_ld    = 1'b1;
                            w_tx_byte  = w_undr_byte;
                            w_undr_clr = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ARG1: begin
                    case (r_op)
                        OP_RD_REG: begin
                            w_tx_ld     = 1'b1;
                            w_tx_byte   = w_reg_rd;
                            w_state_nxt = IDLE;
                        end
                        OP_RD_LVL: begin
                            w_tx_ld     = 1'b1;
                            w_tx_byte   = w_lvl_rd;
                            w_state_nxt = IDLE;
                        end
                        default: w_state_nxt = ARG2;
                    endcase
                end
                ARG2: begin
                    w_state_nxt = IDLE;
                    // Out-of-range addresses match no register and are dropped.
                    if (r_op == OP_WR_REG) w_reg_we = 1'b1;
                    if (r_op == OP_BURST)  w_start  = (r_arg1 < NUM_CH_B) && (spi_rx_data != 8'd0);
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    spi_burst_reader #(
        .NUM_CH (NUM_CH),
        .FILL   (FILL)
    ) u_burst (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_start),
        .i_ch           (r_arg1),
        .i_len          (spi_rx_data),
        .i_abort        (ssel_n),
        .i_tx_done      (spi_tx_done),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_rd_data (fifo_rd_data),
        .o_fifo_rd_en   (fifo_rd_en),
        .o_underrun_set (w_undr_set),
        .o_tx_ld        (w_burst_ld),
        .o_tx_byte      (w_burst_byte),
        .o_busy         (w_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_arg1     <= '0;
            r_tx       <= '0;
            r_ctrl     <= '0;
            r_underrun <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rx && r_state == IDLE) r_op   <= spi_rx_data;
            if (w_rx && r_state == ARG1) r_arg1 <= spi_rx_data;
            if (w_reg_we)
                for (int k = 0; k < NUM_REGS; k++)
                    if (r_arg1 == 8'(k)) r_ctrl[8*k +: 8] <= spi_rx_data;
            if (w_tx_ld)         r_tx <= w_tx_byte;
            else if (w_burst_ld) r_tx <= w_burst_byte;
            // Set wins over a simultaneous clear.
            r_underrun <= (r_underrun & ~{NUM_CH{w_undr_clr}}) | w_undr_set;
        end
    end

    assign spi_tx_data = r_tx;
    assign ctrl_regs   = r_ctrl;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
module tb_spi_cmd_bridge;
    localparam int NUM_CH = 2, NUM_REGS = 4, LVL_W = 6;
    localparam logic [7:0] FILL = 8'hFF;

    logic clk = 1'b0, rst = 1'b0, ssel_n = 1'b1;
    logic spi_rx_valid = 1'b0, spi_tx_done = 1'b0;
    logic [7:0] spi_rx_data = '0;
    logic [7:0] spi_tx_data;
    logic [8*NUM_REGS-1:0] ctrl_regs;
    logic [NUM_CH-1:0] fifo_rd_en, fifo_empty, underrun;
    logic [8*NUM_CH-1:0] fifo_rd_data = '0;
    logic [LVL_W*NUM_CH-1:0] fifo_level = '0;

    always #5 clk = ~clk;

    spi_cmd_bridge #(.NUM_CH(NUM_CH), .NUM_REGS(NUM_REGS), .LVL_W(LVL_W), .FILL(FILL)) dut (
        .clk(clk), .rst(rst), .ssel_n(ssel_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid), .spi_tx_done(spi_tx_done),
        .spi_tx_data(spi_tx_data), .ctrl_regs(ctrl_regs),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level), .underrun(underrun));

    // FIFO emulation
    logic [7:0] fmem [NUM_CH][64];
    int wp [NUM_CH];
    int rp [NUM_CH];
    int rd_total = 0;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_empty
        assign fifo_empty[g] = (wp[g] == rp[g]);
    end
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (fifo_rd_en[c] && wp[c] != rp[c]) begin
                fifo_rd_data[8*c +: 8] <= fmem[c][rp[c] % 64];
                rp[c] <= rp[c] + 1;
            end
        rd_total <= rd_total + $countones(fifo_rd_en);
    end

    // Behavioural model state
    logic [7:0] mq [NUM_CH][$];
    logic [8*NUM_REGS-1:0] m_regs = '0;
    logic [7:0] m_tx = '0;
    logic [NUM_CH-1:0] m_und = '0;
    bit chk_en = 1'b0;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    logic [NUM_CH-1:0] prev_rd = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (chk_en) begin
                check("tx_data", spi_tx_data, m_tx);
                check("ctrl_regs", ctrl_regs, m_regs);
                check("underrun", underrun, m_und);
                check("rd_en_idle", fifo_rd_en, 0);
            end
            check("rd_en_onehot", ($countones(fifo_rd_en) <= 1) && ((fifo_rd_en & prev_rd) == 0), 1);
        end
        prev_rd <= fifo_rd_en;
    end

    task automatic push(input int c, input logic [7:0] b);
        fmem[c][wp[c] % 64] = b;
        wp[c]++;
        mq[c].push_back(b);
    endtask

    task automatic flush(input int c);
        wp[c] = rp[c];
        mq[c].delete();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        spi_rx_data = b;
        spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_rx_valid = 1'b0;
    endtask

    // End of frame; an opcode-looking dummy byte arrives with it.
    task automatic tx_pulse();
        @(negedge clk);
        spi_tx_done = 1'b1;
        spi_rx_data = 8'h07;
        spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_tx_done = 1'b0;
        spi_rx_valid = 1'b0;
    endtask

    task automatic wr_reg(input int a, input logic [7:0] d);
        rx_byte(8'h02); rx_byte(8'(a)); rx_byte(d);
        if (a < NUM_REGS) m_regs[8*a +: 8] = d;
    endtask

    task automatic rd_reg(input int a);
        rx_byte(8'h03); rx_byte(8'(a));
        if (a < NUM_REGS) m_tx = m_regs[8*a +: 8];
        else m_tx = 8'h00;
    endtask

    task automatic rd_lvl(input int c);
        rx_byte(8'h05); rx_byte(8'(c));
        if (c < NUM_CH) m_tx = 8'(fifo_level[c*LVL_W +: LVL_W]);
        else m_tx = 8'h00;
    endtask

    task automatic rd_undr();
        rx_byte(8'h07);
        m_tx = 8'(m_und);
        m_und = '0;
    endtask

    task automatic burst(input int c, input int len);
        logic [7:0] exp [$];
        logic [7:0] cs;
        int rd0, nrd;
        cs = 8'h00; nrd = 0;
        rx_byte(8'hCC); rx_byte(8'(c));
        chk_en = 1'b0;
        rd0 = rd_total;
        rx_byte(8'(len));
        if (c < NUM_CH && len != 0) begin
            for (int i = 0; i < len; i++) begin
                if (mq[c].size() > 0) begin exp.push_back(mq[c].pop_front()); nrd++; end
                else begin exp.push_back(FILL); m_und[c] = 1'b1; end
                cs ^= exp[i];
            end
            for (int i = 0; i < len; i++) begin
                repeat (4) @(posedge clk); #1;
                check($sformatf("burst_ch%0d_b%0d", c, i), spi_tx_data, exp[i]);
                tx_pulse();
            end
`ifdef SPI_CMD_BRIDGE_CSUM_EN
            repeat (4) @(posedge clk); #1;
            check("burst_csum", spi_tx_data, cs);
            tx_pulse();
            m_tx = cs;
`else
            m_tx = exp[len-1];
`endif
        end
        repeat (3) @(posedge clk); #1;
        check("burst_reads", rd_total - rd0, nrd);
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, rd1;
        repeat (3) @(posedge clk); #1;
        check("rst_tx", spi_tx_data, 0);
        check("rst_regs", ctrl_regs, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk); rst = 1'b1; ssel_n = 1'b0; chk_en = 1'b1;

        // register write / read
        wr_reg(1, 8'hA5);
        rd_reg(1);
        @(negedge clk);
        check("lit_reg1", ctrl_regs[15:8], 8'hA5);
        check("lit_rd_reg1", spi_tx_data, 8'hA5);
        wr_reg(2, 8'h3C);

        // level reads
        fifo_level = {6'h2A, 6'h05};
        rd_lvl(7);
        @(negedge clk); check("lit_lvl_oor", spi_tx_data, 8'h00);
        rd_lvl(1);
        @(negedge clk); check("lit_lvl1", spi_tx_data, 8'h2A);

        // unknown opcode leaves decoder idle
        rx_byte(8'h99);
        rd_reg(2);
        @(negedge clk); check("lit_after_99", spi_tx_data, 8'h3C);

        // normal burst on ch1
        push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
        burst(1, 4);

        // underrun burst on ch0
        push(0, 8'h5A);
        burst(0, 3);
        check("lit_underrun_set", underrun, 2'b01);
        rd_undr();
        @(negedge clk);
        check("lit_undr_tx", spi_tx_data, 8'h01);
        check("lit_undr_clr", underrun, 2'b00);

        // out-of-range and zero-length
        wr_reg(9, 8'h77);
        rd_reg(5);
        @(negedge clk); check("lit_rd_oor", spi_tx_data, 8'h00);
        push(1, 8'h66);
        burst(3, 2);
        burst(1, 0);
        flush(1);

        // abort after second frame
        for (int i = 0; i < 10; i++) push(0, 8'hA0 + 8'(i));
        rx_byte(8'hCC); rx_byte(8'h00);
        chk_en = 1'b0;
        rd0 = rd_total;
        rx_byte(8'd8);
        for (int i = 0; i < 2; i++) begin
            repeat (4) @(posedge clk); #1;
            check($sformatf("abort_b%0d", i), spi_tx_data, 8'hA0 + 8'(i));
            tx_pulse();
        end
        ssel_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("abort_reads_le3", (rd_total - rd0) <= 3, 1);
        rd1 = rd_total;
        repeat (20) @(posedge clk); #1;
        check("abort_no_strobes", rd_total, rd1);
        check("abort_tx_hold", spi_tx_data, 8'hA1);
        @(negedge clk); ssel_n = 1'b0;
        flush(0);
        m_tx = 8'hA1;
        chk_en = 1'b1;
        rd_reg(2);

        // reset in the middle of a burst
        push(1, 8'h01); push(1, 8'h02); push(1, 8'h03); push(1, 8'h04);
        rx_byte(8'hCC); rx_byte(8'h01);
        chk_en = 1'b0;
        rx_byte(8'd4);
        repeat (4) @(posedge clk); #1;
        tx_pulse();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_tx", spi_tx_data, 0);
        check("midrst_regs", ctrl_regs, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_underrun", underrun, 0);
        m_regs = '0; m_tx = '0; m_und = '0;
        @(negedge clk); rst = 1'b1;
        flush(1);
        chk_en = 1'b1;
        wr_reg(3, 8'h81);
        rd_reg(3);
        @(negedge clk); check("lit_rd_reg3", spi_tx_data, 8'h81);
        rd_reg(0);
        @(negedge clk); check("lit_rd_reg0_after_rst", spi_tx_data, 8'h00);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
